// File: rtl/dotmatrix_scan_ctrl.sv
// Row-scan controller for an LED dot-matrix: double-buffered frame memory with
// frame-boundary swaps, per-slot anti-ghost blanking and circular horizontal scroll.
module dotmatrix_scan_ctrl #(
    parameter int N_LINES         = 8,
    parameter int N_PIX           = 8,
    parameter int SCAN_DIV        = 27000,
    parameter int BLANK_CYC       = 16,
    parameter int SCROLL_FRAMES   = 16,
    parameter bit SEL_ACTIVE_HIGH = 1'b1,
    parameter bit PIX_ACTIVE_LOW  = 1'b1,
    localparam int AW = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [N_PIX-1:0]   i_wr_data,
    input  logic               i_swap_req,
    output logic               o_swap_busy,
    input  logic               i_scroll_en,
    input  logic               i_scroll_dir,
    output logic [N_LINES-1:0] Col_LED,
    output logic [N_PIX-1:0]   Row_LED,
    output logic               o_frame_start
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int OW = $clog2(N_PIX);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [TW-1:0]      TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0]      BLANK_END = TW'(BLANK_CYC);
    localparam logic [AW-1:0]      LINE_LAST = AW'(N_LINES - 1);
    localparam logic [FW-1:0]      FRM_LAST  = FW'(SCROLL_FRAMES - 1);
    localparam logic [OW-1:0]      OFF_LAST  = OW'(N_PIX - 1);
    localparam logic [N_LINES-1:0] SEL_OFF   = SEL_ACTIVE_HIGH ? '0 : '1;
    localparam logic [N_PIX-1:0]   PIX_OFF   = PIX_ACTIVE_LOW ? '1 : '0;

    logic [TW-1:0] tick_reg;
    logic [AW-1:0] line_reg;
    logic          front_sel_reg;
    logic          swap_pend_reg;
    logic [FW-1:0] frame_cnt_reg;
    logic [OW-1:0] offset_reg;
    logic [OW-1:0] offset_next;

    logic               tick_wrap;
    logic               frame_bnd;
    logic               blank;
    logic [N_PIX-1:0]   front_line [N_LINES];
    logic [N_PIX-1:0]   cur_line;
    logic [N_PIX-1:0]   rot_line;
    logic [N_LINES-1:0] sel_onehot;

    assign tick_wrap   = (tick_reg == TICK_LAST);
    assign frame_bnd   = tick_wrap && (line_reg == LINE_LAST);
    assign blank       = (BLANK_CYC != 0) && (tick_reg < BLANK_END);
    assign o_swap_busy = swap_pend_reg;

    always_comb begin
        offset_next = offset_reg;
        if (i_scroll_dir)
            offset_next = (offset_reg == '0) ? OFF_LAST : offset_reg - 1'b1;
        else
            offset_next = (offset_reg == OFF_LAST) ? '0 : offset_reg + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tick_reg      <= '0;
            line_reg      <= '0;
            front_sel_reg <= 1'b0;
            swap_pend_reg <= 1'b0;
            frame_cnt_reg <= '0;
            offset_reg    <= '0;
        end else begin
            if (tick_wrap) begin
                tick_reg <= '0;
                line_reg <= frame_bnd ? '0 : line_reg + 1'b1;
            end else begin
                tick_reg <= tick_reg + 1'b1;
            end

            // A request landing on the boundary cycle itself is honoured immediately.
            if (frame_bnd && (swap_pend_reg || i_swap_req)) begin
                front_sel_reg <= ~front_sel_reg;
                swap_pend_reg <= 1'b0;
            end else if (i_swap_req) begin
                swap_pend_reg <= 1'b1;
            end

            if (frame_bnd && i_scroll_en) begin
                if (frame_cnt_reg == FRM_LAST) begin
                    frame_cnt_reg <= '0;
                    offset_reg    <= offset_next;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Each line owns one word in each buffer; writes always go to the non-displayed one.
    genvar gi;
    generate
        for (gi = 0; gi < N_LINES; gi++) begin : g_line
            logic [N_PIX-1:0] buf0_reg;
            logic [N_PIX-1:0] buf1_reg;
            logic             hit;

            assign hit = i_wr_en && (i_wr_addr == AW'(gi));

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    buf0_reg <= '0;
                    buf1_reg <= '0;
                end else if (hit) begin
                    if (front_sel_reg)
                        buf0_reg <= i_wr_data;
                    else
                        buf1_reg <= i_wr_data;
                end
            end

            assign front_line[gi] = front_sel_reg ? buf1_reg : buf0_reg;
        end
    endgenerate

    always_comb begin
        cur_line   = front_line[line_reg];
        rot_line   = N_PIX'({cur_line, cur_line} >> offset_reg);
        sel_onehot = {{(N_LINES-1){1'b0}}, 1'b1} << line_reg;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            Col_LED       <= SEL_OFF;
            Row_LED       <= PIX_OFF;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= (tick_reg == '0) && (line_reg == '0);
            if (blank) begin
                Col_LED <= SEL_OFF;
                Row_LED <= PIX_OFF;
            end else begin
                Col_LED <= SEL_ACTIVE_HIGH ? sel_onehot : ~sel_onehot;
                Row_LED <= PIX_ACTIVE_LOW ? ~rot_line : rot_line;
            end
        end
    end

endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// Directed bench for dotmatrix_scan_ctrl: a 4x4 instance for scan, swap, scroll and
// reset behaviour, and a 3-line instance for out-of-range write addresses.
module tb_dotmatrix_scan_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESETn;
    logic       wr_en, swap_req, scroll_en, scroll_dir;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       swap_busy, frame_start;
    logic [3:0] col, row;

    logic       wr_en3, swap_req3, zero3;
    logic [1:0] wr_addr3;
    logic [3:0] wr_data3;
    logic       swap_busy3, frame_start3;
    logic [2:0] col3;
    logic [3:0] row3;

    int n_cmp = 0;
    int n_err = 0;
    int n;
    logic [15:0] scroll_exp [13];

    dotmatrix_scan_ctrl #(
        .N_LINES(4), .N_PIX(4), .SCAN_DIV(10), .BLANK_CYC(2), .SCROLL_FRAMES(2),
        .SEL_ACTIVE_HIGH(1'b1), .PIX_ACTIVE_LOW(1'b1)
    ) u_dut (
        .CLK(CLK), .RESETn(RESETn),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_swap_req(swap_req), .o_swap_busy(swap_busy),
        .i_scroll_en(scroll_en), .i_scroll_dir(scroll_dir),
        .Col_LED(col), .Row_LED(row), .o_frame_start(frame_start)
    );

    dotmatrix_scan_ctrl #(
        .N_LINES(3), .N_PIX(4), .SCAN_DIV(10), .BLANK_CYC(2), .SCROLL_FRAMES(2),
        .SEL_ACTIVE_HIGH(1'b1), .PIX_ACTIVE_LOW(1'b1)
    ) u_dut3 (
        .CLK(CLK), .RESETn(RESETn),
        .i_wr_en(wr_en3), .i_wr_addr(wr_addr3), .i_wr_data(wr_data3),
        .i_swap_req(swap_req3), .o_swap_busy(swap_busy3),
        .i_scroll_en(zero3), .i_scroll_dir(zero3),
        .Col_LED(col3), .Row_LED(row3), .o_frame_start(frame_start3)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Advance until the selected instance shows o_frame_start; n = cycles taken.
    task automatic sync_frame(input bit use3, output int cyc);
        logic found;
        found = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cyc++;
            if ((use3 ? frame_start3 : frame_start) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check_val("sync_frame_start", {31'd0, found}, 32'd1);
    endtask

    // Checks one full 40-cycle frame of the 4x4 instance; lit holds pre-polarity
    // line data (line l at [4l+3:4l]) after scrolling.
    task automatic check_frame(input logic [15:0] lit, input int swap_at, input bit bnd_wr);
        for (int c = 0; c < 40; c++) begin
            int t;
            int l;
            logic [3:0] ec;
            logic [3:0] er;
            t = c % 10;
            l = c / 10;
            if (t < 2) begin
                ec = 4'b0000;
                er = 4'b1111;
            end else begin
                ec = 4'b0001 << l;
                er = ~lit[4*l +: 4];
            end
            check_val($sformatf("col_c%0d", c), {28'd0, col}, {28'd0, ec});
            check_val($sformatf("row_c%0d", c), {28'd0, row}, {28'd0, er});
            check_val($sformatf("fstart_c%0d", c), {31'd0, frame_start}, {31'd0, (c == 0)});
            if (swap_at >= 0 && (c == swap_at || c == swap_at + 3))
                swap_req = 1'b1;
            if (bnd_wr && c == 38) begin
                wr_en   = 1'b1;
                wr_addr = 2'd2;
                wr_data = 4'b0110;
            end
            step();
            swap_req = 1'b0;
            wr_en    = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scroll_exp = '{16'h8421, 16'h8421, 16'h4218, 16'h4218, 16'h2184, 16'h2184,
                       16'h1842, 16'h1842, 16'h8421, 16'h8421, 16'h1842, 16'h1842,
                       16'h1842};
        RESETn = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        scroll_en = 1'b0; scroll_dir = 1'b0;
        wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; swap_req3 = 1'b0; zero3 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        check_val("rst_col", {28'd0, col}, 32'h0);
        check_val("rst_row", {28'd0, row}, 32'hF);
        check_val("rst_fstart", {31'd0, frame_start}, 32'd0);
        check_val("rst_busy", {31'd0, swap_busy}, 32'd0);
        check_val("rst_col3", {29'd0, col3}, 32'h0);

        RESETn = 1'b1;
        sync_frame(1'b0, n);
        check_val("first_fstart_latency", n, 32'd1);
        check_frame(16'h0000, -1, 1'b0);

        // Fill the back buffer; nothing may appear before a swap.
        for (int l = 0; l < 4; l++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(l);
            wr_data = 4'(1 << l);
            step();
        end
        wr_en = 1'b0;
        sync_frame(1'b0, n);
        check_frame(16'h0000, -1, 1'b0);

        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check_val("busy_rise", {31'd0, swap_busy}, 32'd1);
        repeat (20) step();
        check_val("busy_hold", {31'd0, swap_busy}, 32'd1);
        sync_frame(1'b0, n);
        check_val("busy_clear", {31'd0, swap_busy}, 32'd0);

        // Mid-frame double swap request plus a boundary-cycle write to line 2.
        check_frame(16'h8421, 15, 1'b1);
        check_val("busy_after_bnd_swap", {31'd0, swap_busy}, 32'd0);
        check_frame(16'h0600, 5, 1'b0);

        scroll_en = 1'b1;
        for (int f = 0; f < 13; f++) begin
            if (f == 8)
                scroll_dir = 1'b1;
            if (f == 11)
                scroll_en = 1'b0;
            check_frame(scroll_exp[f], -1, 1'b0);
        end

        // Asynchronous reset in the middle of line 1 with a swap pending.
        step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check_val("pre_rst_busy", {31'd0, swap_busy}, 32'd1);
        repeat (10) step();
        check_val("pre_rst_col", {28'd0, col}, 32'h2);
        check_val("pre_rst_row", {28'd0, row}, 32'hB);
        #1;
        RESETn = 1'b0;
        #1;
        check_val("midrst_col", {28'd0, col}, 32'h0);
        check_val("midrst_row", {28'd0, row}, 32'hF);
        check_val("midrst_fstart", {31'd0, frame_start}, 32'd0);
        check_val("midrst_busy", {31'd0, swap_busy}, 32'd0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        sync_frame(1'b0, n);
        check_val("post_rst_fstart_latency", n, 32'd1);
        check_frame(16'h0000, -1, 1'b0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        sync_frame(1'b0, n);
        check_frame(16'h0000, -1, 1'b0);

        // Three-line instance: address 3 is out of range and must be dropped.
        wr_en3   = 1'b1;
        wr_addr3 = 2'd3;
        wr_data3 = 4'b1111;
        step();
        wr_addr3 = 2'd1;
        wr_data3 = 4'b0101;
        step();
        wr_en3    = 1'b0;
        swap_req3 = 1'b1;
        step();
        swap_req3 = 1'b0;
        sync_frame(1'b1, n);
        for (int c = 0; c < 30; c++) begin
            if (c == 5) begin
                check_val("n3_line0_col", {29'd0, col3}, 32'h1);
                check_val("n3_line0_row", {28'd0, row3}, 32'hF);
            end
            if (c == 15) begin
                check_val("n3_line1_col", {29'd0, col3}, 32'h2);
                check_val("n3_line1_row", {28'd0, row3}, 32'hA);
            end
            if (c == 25) begin
                check_val("n3_line2_col", {29'd0, col3}, 32'h4);
                check_val("n3_line2_row", {28'd0, row3}, 32'hF);
            end
            step();
        end
        check_val("n3_frame_period", {31'd0, frame_start3}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
